// File: rtl/sound_dispatcher_if.sv
// Handshake bundle between the game logic, the sound dispatcher and the sound player.
// The master side raises events and reports player activity; the slave side is the dispatcher.
interface sound_dispatcher_if #(
    parameter int FIFO_DEPTH = 4
);
    logic [6:0]                  evt_req;
    logic                        player_busy;
    logic                        flags_clr;
    logic                        play_sound;
    logic [2:0]                  sound_code;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        overflow;
    logic                        ack_timeout;

    modport master (
        output evt_req, player_busy, flags_clr,
        input  play_sound, sound_code, fifo_count, overflow, ack_timeout
    );

    modport slave (
        input  evt_req, player_busy, flags_clr,
        output play_sound, sound_code, fifo_count, overflow, ack_timeout
    );
endinterface

// File: rtl/sound_dispatcher.sv
// Queues prioritised game sound events and hands them one at a time to the sound player,
// letting "game over" flush the queue and cut into a sound that is still playing.
module sound_dispatcher #(
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input logic               clk,
    input logic               rst,
    sound_dispatcher_if.slave bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t          state;
    logic [2:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [TW-1:0]   tcnt;
    logic            play_sound;
    logic [2:0]      sound_code;
    logic            overflow;
    logic            ack_timeout;

    logic [2:0]      acc_code;
    logic [2:0]      head_code;
    logic            game_over;
    logic            push_req;
    logic            push_ok;
    logic            drop;
    logic            issue_now;
    logic            timeout_hit;

    // Highest set strobe wins because later loop iterations overwrite earlier ones.
    always_comb begin
        acc_code = '0;
        for (int i = 0; i < 7; i++) begin
            if (bus.evt_req[i]) begin
                acc_code = 3'(i + 1);
            end
        end
    end

    always_comb begin
        head_code   = mem[rd_ptr];
        game_over   = (acc_code == 3'd7);
        push_req    = (acc_code != 3'd0) && !game_over;
        issue_now   = (count != '0) &&
                      (((state == IDLE) && !bus.player_busy) ||
                       ((state == WAIT_DONE) && (head_code == 3'd7)));
        push_ok     = push_req && ((count != CW'(FIFO_DEPTH)) || issue_now);
        drop        = push_req && (count == CW'(FIFO_DEPTH)) && !issue_now;
        timeout_hit = (state == WAIT_ACK) && !bus.player_busy &&
                      (tcnt == TW'(ACK_TIMEOUT - 1));
    end

    // Storage needs no reset: only entries counted by the pointers are ever read.
    always_ff @(posedge clk) begin
        if (game_over) begin
            mem[0] <= 3'd7;
        end else if (push_ok) begin
            mem[wr_ptr] <= acc_code;
        end
    end

    // A game-over flush overrides any simultaneous pop; the popped sound has already been issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (game_over) begin
            rd_ptr <= '0;
            wr_ptr <= AW'(1);
            count  <= CW'(1);
        end else begin
            if (issue_now) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            case ({push_ok, issue_now})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // The pulse is launched on entry to ISSUE, so it is high exactly while the FSM sits there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            play_sound  <= 1'b0;
            sound_code  <= 3'd0;
            tcnt        <= '0;
            overflow    <= 1'b0;
            ack_timeout <= 1'b0;
        end else begin
            play_sound <= 1'b0;
            case (state)
                IDLE: begin
                    if (issue_now) begin
                        state      <= ISSUE;
                        play_sound <= 1'b1;
                        sound_code <= head_code;
                    end
                end
                ISSUE: begin
                    state <= WAIT_ACK;
                    tcnt  <= '0;
                end
                WAIT_ACK: begin
                    if (bus.player_busy) begin
                        state <= WAIT_DONE;
                    end else if (timeout_hit) begin
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (issue_now) begin
                        state      <= ISSUE;
                        play_sound <= 1'b1;
                        sound_code <= head_code;
                    end else if (!bus.player_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (drop) begin
                overflow <= 1'b1;
            end else if (bus.flags_clr) begin
                overflow <= 1'b0;
            end

            if (timeout_hit) begin
                ack_timeout <= 1'b1;
            end else if (bus.flags_clr) begin
                ack_timeout <= 1'b0;
            end
        end
    end

    assign bus.play_sound  = play_sound;
    assign bus.sound_code  = sound_code;
    assign bus.fifo_count  = count;
    assign bus.overflow    = overflow;
    assign bus.ack_timeout = ack_timeout;
endmodule

// File: tb/tb_sound_dispatcher.sv
// Self-checking bench for sound_dispatcher: a vector table for arbitration and queueing,
// hand-written sequences for overflow, game-over preemption, ack timeout and mid-run reset.
module tb_sound_dispatcher;
    logic clk;
    logic rst;

    sound_dispatcher_if #(.FIFO_DEPTH(4)) bus ();

    sound_dispatcher #(
        .FIFO_DEPTH (4),
        .ACK_TIMEOUT(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    bit prev_pulse = 1'b0;

    typedef struct {
        logic [6:0] evt;
        int         code;
        int         count;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int highestCode(input logic [6:0] evt);
        for (int i = 6; i >= 0; i--) begin
            if (evt[i]) return i + 1;
        end
        return 0;
    endfunction

    // Drives one strobe cycle; the scoreboard learns what should eventually play.
    task automatic applyStimulus(input logic [6:0] evt, input bit clr, input bit accept);
        int code;
        code = highestCode(evt);
        if (code == 7) begin
            exp_q.delete();
            exp_q.push_back(7);
        end else if (code != 0 && accept) begin
            exp_q.push_back(code);
        end
        bus.evt_req   = evt;
        bus.flags_clr = clr;
        tick();
        bus.evt_req   = '0;
        bus.flags_clr = 1'b0;
    endtask

    task automatic resetDut();
        rst             = 1'b1;
        bus.evt_req     = '0;
        bus.player_busy = 1'b0;
        bus.flags_clr   = 1'b0;
        repeat (2) tick();
        exp_q.delete();
        rst = 1'b0;
        tick();
    endtask

    // Waits for a pulse, then plays the sound for a few cycles; reports cycles waited.
    task automatic serveOne(output int waited);
        waited = 0;
        while (!bus.play_sound && waited < 12) begin
            tick();
            waited++;
        end
        checks++;
        if (!bus.play_sound) begin
            failures++;
            $display("[TB] FAIL pulse_wait: got no play_sound, expected one within 12 cycles");
        end
        bus.player_busy = 1'b1;
        repeat (3) tick();
        bus.player_busy = 1'b0;
    endtask

    // Every pulse is matched against the oldest expected code.
    always @(negedge clk) begin
        int e;
        if (bus.play_sound) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_pulse: got code %0d, expected no pulse", bus.sound_code);
            end else begin
                e = exp_q.pop_front();
                if (int'(bus.sound_code) != e) begin
                    failures++;
                    $display("[TB] FAIL pulse_code: got %0d, expected %0d", bus.sound_code, e);
                end
            end
            if (prev_pulse) begin
                failures++;
                $display("[TB] FAIL pulse_spacing: got 2 consecutive pulses, expected 1");
            end
        end
        prev_pulse = bus.play_sound;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waited;

        vecs[0] = '{7'b0000100, 3, 1};
        vecs[1] = '{7'b0010011, 5, 1};
        vecs[2] = '{7'b0000001, 1, 1};
        vecs[3] = '{7'b0100001, 6, 1};
        vecs[4] = '{7'b0011111, 5, 1};
        vecs[5] = '{7'b1000000, 7, 1};
        vecs[6] = '{7'b1111111, 7, 1};
        vecs[7] = '{7'b0000000, 0, 0};

        clk = 1'b0;
        resetDut();
        checkOutput("reset_play_sound", bus.play_sound, 0);
        checkOutput("reset_sound_code", bus.sound_code, 0);
        checkOutput("reset_fifo_count", bus.fifo_count, 0);
        checkOutput("reset_overflow", bus.overflow, 0);
        checkOutput("reset_ack_timeout", bus.ack_timeout, 0);

        // Arbitration table: player busy keeps the request queued until it is inspected.
        for (int i = 0; i < 8; i++) begin
            resetDut();
            bus.player_busy = 1'b1;
            tick();
            applyStimulus(vecs[i].evt, 1'b0, 1'b1);
            checkOutput($sformatf("vec%0d_count", i), bus.fifo_count, vecs[i].count);
            checkOutput($sformatf("vec%0d_overflow", i), bus.overflow, 0);
            checkOutput($sformatf("vec%0d_ack_timeout", i), bus.ack_timeout, 0);
            bus.player_busy = 1'b0;
            if (vecs[i].code != 0) begin
                serveOne(waited);
            end
            repeat (4) tick();
            checkOutput($sformatf("vec%0d_drained", i), exp_q.size(), 0);
        end

        // Single event with an idle player: pulse two cycles after the strobe.
        resetDut();
        applyStimulus(7'b0000100, 1'b0, 1'b1);
        checkOutput("single_count_after_strobe", bus.fifo_count, 1);
        checkOutput("single_no_early_pulse", bus.play_sound, 0);
        tick();
        checkOutput("single_pulse", bus.play_sound, 1);
        checkOutput("single_code", bus.sound_code, 3);
        checkOutput("single_count_after_pop", bus.fifo_count, 0);
        bus.player_busy = 1'b1;
        tick();
        checkOutput("single_pulse_one_cycle", bus.play_sound, 0);
        tick();
        bus.player_busy = 1'b0;
        repeat (3) tick();
        checkOutput("single_code_held", bus.sound_code, 3);

        // Overflow, set-beats-clear, and push accepted while full because of a same-cycle pop.
        resetDut();
        bus.player_busy = 1'b1;
        tick();
        for (int c = 1; c <= 4; c++) begin
            logic [6:0] ev;
            ev = 7'(1 << (c - 1));
            applyStimulus(ev, 1'b0, 1'b1);
        end
        checkOutput("full_count", bus.fifo_count, 4);
        checkOutput("full_no_overflow", bus.overflow, 0);
        applyStimulus(7'b0010000, 1'b1, 1'b0);
        checkOutput("overflow_set_beats_clear", bus.overflow, 1);
        checkOutput("overflow_count", bus.fifo_count, 4);
        tick();
        checkOutput("overflow_sticky", bus.overflow, 1);
        applyStimulus(7'b0000000, 1'b1, 1'b0);
        checkOutput("overflow_cleared", bus.overflow, 0);
        bus.player_busy = 1'b0;
        applyStimulus(7'b0100000, 1'b0, 1'b1);
        checkOutput("full_push_with_pop_count", bus.fifo_count, 4);
        checkOutput("full_push_with_pop_no_overflow", bus.overflow, 0);
        checkOutput("full_push_with_pop_pulse", bus.play_sound, 1);
        serveOne(waited);
        for (int k = 0; k < 4; k++) begin
            serveOne(waited);
            checkOutput($sformatf("busy_fall_gap%0d", k), waited, 2);
        end
        repeat (4) tick();
        checkOutput("overflow_drained", exp_q.size(), 0);
        checkOutput("overflow_final_count", bus.fifo_count, 0);

        // Game over preempts a sound still playing and discards the queued ones.
        resetDut();
        applyStimulus(7'b0001000, 1'b0, 1'b1);
        tick();
        checkOutput("go_first_pulse", bus.play_sound, 1);
        bus.player_busy = 1'b1;
        repeat (2) tick();
        applyStimulus(7'b0000001, 1'b0, 1'b1);
        applyStimulus(7'b0000010, 1'b0, 1'b1);
        applyStimulus(7'b0000100, 1'b0, 1'b1);
        checkOutput("go_queued_count", bus.fifo_count, 3);
        applyStimulus(7'b1000000, 1'b0, 1'b1);
        checkOutput("go_flush_count", bus.fifo_count, 1);
        waited = 0;
        while (!bus.play_sound && waited < 3) begin
            tick();
            waited++;
        end
        checkOutput("go_preempt_pulse", bus.play_sound, 1);
        checkOutput("go_busy_still_high", bus.player_busy, 1);
        checkOutput("go_count_after_pop", bus.fifo_count, 0);
        repeat (3) tick();
        bus.player_busy = 1'b0;
        repeat (10) tick();
        checkOutput("go_drained", exp_q.size(), 0);

        // Player never acknowledges: the flag rises after sixteen cycles in WAIT_ACK.
        resetDut();
        applyStimulus(7'b0000010, 1'b0, 1'b1);
        tick();
        checkOutput("to_pulse", bus.play_sound, 1);
        repeat (16) tick();
        checkOutput("to_not_yet", bus.ack_timeout, 0);
        tick();
        checkOutput("to_flag_set", bus.ack_timeout, 1);
        repeat (5) tick();
        checkOutput("to_flag_sticky", bus.ack_timeout, 1);
        applyStimulus(7'b0000000, 1'b1, 1'b0);
        checkOutput("to_flag_cleared", bus.ack_timeout, 0);

        // Reset while playing with two requests queued: everything clears at once.
        resetDut();
        applyStimulus(7'b0001000, 1'b0, 1'b1);
        tick();
        bus.player_busy = 1'b1;
        repeat (2) tick();
        applyStimulus(7'b0000001, 1'b0, 1'b1);
        applyStimulus(7'b0000010, 1'b0, 1'b1);
        checkOutput("rst_queued_count", bus.fifo_count, 2);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        checkOutput("rst_async_count", bus.fifo_count, 0);
        checkOutput("rst_async_code", bus.sound_code, 0);
        checkOutput("rst_async_play", bus.play_sound, 0);
        repeat (2) tick();
        rst = 1'b0;
        bus.player_busy = 1'b0;
        repeat (20) tick();
        checkOutput("rst_post_count", bus.fifo_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
